// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and constants for the WS2812 pixel feeder.
//   state_t         - feeder FSM states (SCALE only reachable with WS2812_BRIGHTNESS_EN)
//   CH_W / PIX_W    - channel and pixel widths
//   *_OFF           - input RGB and output GRB field offsets
//   rgb_to_grb()    - reorders an upstream RGB word into driver GRB order
package ws2812_pkg;
  localparam int CH_W  = 8;
  localparam int PIX_W = 24;

  // upstream pixel layout
  localparam int IN_R_OFF = 16;
  localparam int IN_G_OFF = 8;
  localparam int IN_B_OFF = 0;

  // driver word layout
  localparam int G_OFF = 16;
  localparam int R_OFF = 8;
  localparam int B_OFF = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic logic [PIX_W-1:0] rgb_to_grb(input logic [PIX_W-1:0] rgb);
    logic [PIX_W-1:0] grb;
    grb = '0;
    grb[G_OFF +: CH_W] = rgb[IN_G_OFF +: CH_W];
    grb[R_OFF +: CH_W] = rgb[IN_R_OFF +: CH_W];
    grb[B_OFF +: CH_W] = rgb[IN_B_OFF +: CH_W];
    return grb;
  endfunction
endpackage

// File: rtl/ws2812_pixel_feeder_scale.sv
// ws2812_scale: combinational brightness scaler, three 8x8 channel multipliers.
//   i_rgb [23:0] - pixel, any channel order (order is preserved)
//   i_bri [7:0]  - brightness; each channel becomes (c * (bri + 1)) >> 8
//   o_rgb [23:0] - scaled pixel
// Compiled only when WS2812_BRIGHTNESS_EN is defined.
`ifdef WS2812_BRIGHTNESS_EN
module ws2812_scale
  import ws2812_pkg::*;
(
  input  logic [PIX_W-1:0] i_rgb,
  input  logic [CH_W-1:0]  i_bri,
  output logic [PIX_W-1:0] o_rgb
);
  // bri + 1 so that 255 maps to an exact identity (c * 256 >> 8 == c)
  logic [CH_W:0] w_mult;
  assign w_mult = {1'b0, i_bri} + 9'd1;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [16:0] w_prod;
    logic        w_unused_bits;
    assign w_prod = 17'(i_rgb[c*CH_W +: CH_W]) * 17'(w_mult);
    assign o_rgb[c*CH_W +: CH_W] = w_prod[CH_W +: CH_W];
    // truncated fraction and the never-set top bit
    assign w_unused_bits = ^{w_prod[16], w_prod[CH_W-1:0]};
  end
endmodule
`endif

// File: rtl/ws2812_pixel_feeder.sv
// ws2812_pixel_feeder: turns a valid/ready pixel stream into indexed GRB write
// strobes for a WS2812 driver.
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   s_valid/s_ready - pixel handshake; s_ready only in IDLE
//   s_rgb, s_sof    - pixel (RGB) and start-of-frame marker
//   brightness      - global brightness, sampled on accept
//   wr_rgb, wr_led_num, wr_write - driver write port (GRB word, index, strobe)
//   frame_done      - pulses with the write of index NUM_LEDS-1
//   short_frame     - sticky: s_sof arrived before the frame was complete
// Macro WS2812_BRIGHTNESS_EN: adds the SCALE state and brightness scaling
// (latency 2, 1 pixel / 3 cycles). Undefined: IDLE -> WRITE, unscaled,
// brightness ignored (latency 1, 1 pixel / 2 cycles).
module ws2812_pixel_feeder
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_rgb,
  input  logic             s_sof,
  input  logic [CH_W-1:0]  brightness,
  output logic [PIX_W-1:0] wr_rgb,
  output logic [7:0]       wr_led_num,
  output logic             wr_write,
  output logic             frame_done,
  output logic             short_frame
);
  localparam logic [7:0] LAST_IDX = 8'(NUM_LEDS - 1);

  state_t           r_state, w_next;
  logic             w_accept, w_wr_load;
  logic [7:0]       r_cnt, w_tgt, w_load_idx;
  logic [PIX_W-1:0] w_load_rgb;
  logic [PIX_W-1:0] r_wr_rgb;
  logic [7:0]       r_wr_led_num;
  logic             r_short;

  assign w_accept = s_valid && s_ready;
  // sof forces index 0; the counter then resumes from 1 after the write
  assign w_tgt    = s_sof ? 8'd0 : r_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    s_ready  = 1'b0;
    wr_write = 1'b0;
    case (r_state)
      IDLE: begin
        s_ready = 1'b1;
`ifdef WS2812_BRIGHTNESS_EN
        if (s_valid) w_next = SCALE;
`else
        if (s_valid) w_next = WRITE;
`endif
      end
      SCALE: w_next = WRITE;
      WRITE: begin
        w_next   = IDLE;
        // a reset landing in the WRITE cycle suppresses the strobe
        wr_write = !reset;
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef WS2812_BRIGHTNESS_EN
  logic [PIX_W-1:0] r_pix;
  logic [CH_W-1:0]  r_bri;
  logic [7:0]       r_tgt;
  logic [PIX_W-1:0] w_scaled;

  ws2812_scale u_scale (
    .i_rgb (r_pix),
    .i_bri (r_bri),
    .o_rgb (w_scaled)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix <= '0;
      r_bri <= '0;
      r_tgt <= '0;
    end else if (w_accept) begin
      r_pix <= s_rgb;
      r_bri <= brightness;
      r_tgt <= w_tgt;
    end
  end

  // output registers load on the SCALE -> WRITE edge
  assign w_wr_load  = (r_state == SCALE);
  assign w_load_rgb = w_scaled;
  assign w_load_idx = r_tgt;
`else
  logic w_unused_bri;
  assign w_unused_bri = ^brightness;

  // output registers load directly on the accept edge
  assign w_wr_load  = w_accept;
  assign w_load_rgb = s_rgb;
  assign w_load_idx = w_tgt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_rgb     <= '0;
      r_wr_led_num <= '0;
      r_cnt        <= '0;
      r_short      <= 1'b0;
    end else begin
      if (w_accept && s_sof && (r_cnt != 8'd0)) r_short <= 1'b1;
      if (w_wr_load) begin
        r_wr_rgb     <= rgb_to_grb(w_load_rgb);
        r_wr_led_num <= w_load_idx;
      end
      if (r_state == WRITE)
        r_cnt <= (r_wr_led_num == LAST_IDX) ? 8'd0 : r_wr_led_num + 8'd1;
    end
  end

  assign wr_rgb      = r_wr_rgb;
  assign wr_led_num  = r_wr_led_num;
  assign frame_done  = wr_write && (r_wr_led_num == LAST_IDX);
  assign short_frame = r_short;
endmodule

// File: tb/tb_ws2812_pixel_feeder.sv
// Testbench for ws2812_pixel_feeder (NUM_LEDS=8). Works in both builds:
// expectations follow WS2812_BRIGHTNESS_EN the same way the design does.
module tb_ws2812_pixel_feeder;
  localparam int NUM_LEDS = 8;
`ifdef WS2812_BRIGHTNESS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int PER = LAT + 1;

  logic        clk = 0;
  logic        reset = 1;
  logic        s_valid = 0;
  logic        s_ready;
  logic [23:0] s_rgb = '0;
  logic        s_sof = 0;
  logic [7:0]  brightness = '0;
  logic [23:0] wr_rgb;
  logic [7:0]  wr_led_num;
  logic        wr_write, frame_done, short_frame;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_cnt = 0;
  bit m_short = 0;

  always #5 clk = ~clk;

  ws2812_pixel_feeder #(.NUM_LEDS(NUM_LEDS)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_rgb(s_rgb), .s_sof(s_sof), .brightness(brightness),
    .wr_rgb(wr_rgb), .wr_led_num(wr_led_num), .wr_write(wr_write),
    .frame_done(frame_done), .short_frame(short_frame)
  );

  function automatic logic [23:0] model_grb(input logic [23:0] rgb, input logic [7:0] bri);
    int r, g, b, k;
    r = int'(rgb[23:16]); g = int'(rgb[15:8]); b = int'(rgb[7:0]);
`ifdef WS2812_BRIGHTNESS_EN
    k = int'(bri) + 1;
    r = (r * k) / 256; g = (g * k) / 256; b = (b * k) / 256;
`else
    k = int'(bri);
`endif
    return {g[7:0], r[7:0], b[7:0]};
  endfunction

  task automatic model_accept(input logic [23:0] rgb, input logic sof, input logic [7:0] bri,
                              output logic [23:0] eg, output int ei);
    ei = sof ? 0 : m_cnt;
    if (sof && m_cnt != 0) m_short = 1;
    m_cnt = (ei + 1) % NUM_LEDS;
    eg = model_grb(rgb, bri);
  endtask

  task automatic do_reset();
    reset = 1; s_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    m_cnt = 0; m_short = 0;
  endtask

  // Caller is at #1 after a posedge; returns at the same phase, pixel finished.
  task automatic send_check(input logic [23:0] rgb, input logic sof, input logic [7:0] bri,
                            input string nm);
    logic [23:0] eg;
    int ei, w;
    w = 0;
    while (s_ready !== 1'b1 && w < 10) begin @(posedge clk); #1; w++; end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL %s ready_timeout got=%b want=1", nm, s_ready); end
    s_valid = 1; s_rgb = rgb; s_sof = sof; brightness = bri;
    model_accept(rgb, sof, bri, eg, ei);
    @(posedge clk); #1;
    // junk on idle inputs must be ignored
    s_valid = 0; s_rgb = $urandom; s_sof = 1'($urandom); brightness = 8'($urandom);
    for (int k = 1; k < LAT; k++) begin
      checks++;
      if (wr_write !== 1'b0) begin errors++; $display("FAIL %s early_write got=%b want=0", nm, wr_write); end
      @(posedge clk); #1;
    end
    checks++;
    if (wr_write !== 1'b1) begin errors++; $display("FAIL %s wr_write got=%b want=1", nm, wr_write); end
    checks++;
    if (wr_rgb !== eg) begin errors++; $display("FAIL %s wr_rgb got=%h want=%h", nm, wr_rgb, eg); end
    checks++;
    if (wr_led_num !== 8'(ei)) begin errors++; $display("FAIL %s wr_led_num got=%0d want=%0d", nm, wr_led_num, ei); end
    checks++;
    if (frame_done !== (ei == NUM_LEDS - 1)) begin errors++; $display("FAIL %s frame_done got=%b want=%b", nm, frame_done, ei == NUM_LEDS - 1); end
    checks++;
    if (short_frame !== m_short) begin errors++; $display("FAIL %s short_frame got=%b want=%b", nm, short_frame, m_short); end
    @(posedge clk); #1;
    checks++;
    if (wr_write !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL %s after_write wr_write=%b s_ready=%b want 0/1", nm, wr_write, s_ready);
    end
    checks++;
    if (wr_rgb !== eg) begin errors++; $display("FAIL %s wr_rgb_hold got=%h want=%h", nm, wr_rgb, eg); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({s_ready, wr_write, frame_done, short_frame} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags got=%b want=1000", {s_ready, wr_write, frame_done, short_frame});
    end
    checks++;
    if (wr_rgb !== 24'h0 || wr_led_num !== 8'h0) begin
      errors++; $display("FAIL reset_data got=%h/%0d want=0/0", wr_rgb, wr_led_num);
    end
  endtask

  task automatic test_basic();
    do_reset();
    send_check(24'h112233, 1'b1, 8'd255, "basic");
    checks++;
    if (wr_rgb !== 24'h221133) begin errors++; $display("FAIL basic_const got=%h want=221133", wr_rgb); end
  endtask

  task automatic test_scale();
    logic [23:0] want;
`ifdef WS2812_BRIGHTNESS_EN
    want = 24'h407F20;
`else
    want = 24'h80FF40;
`endif
    do_reset();
    send_check(24'hFF8040, 1'b0, 8'd127, "scale127");
    checks++;
    if (wr_rgb !== want) begin errors++; $display("FAIL scale127_const got=%h want=%h", wr_rgb, want); end
`ifdef WS2812_BRIGHTNESS_EN
    want = 24'h000000;
`else
    want = 24'h80FF40;
`endif
    send_check(24'hFF8040, 1'b0, 8'd0, "scale0");
    checks++;
    if (wr_rgb !== want) begin errors++; $display("FAIL scale0_const got=%h want=%h", wr_rgb, want); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] eg, q_g[$];
    int ei, n, wn;
    do_reset();
    n = 0; wn = 0;
    s_valid = 1; s_sof = 0; s_rgb = $urandom; brightness = 8'($urandom);
    for (int t = 0; t < 9 * PER; t++) begin
      checks++;
      if (s_ready !== (t % PER == 0)) begin
        errors++; $display("FAIL b2b_ready t=%0d got=%b want=%b", t, s_ready, t % PER == 0);
      end
      if (t % PER == 0) begin
        model_accept(s_rgb, s_sof, brightness, eg, ei);
        q_g.push_back(eg);
        n++;
      end
      @(posedge clk); #1;
      if (t % PER == 0) begin s_rgb = $urandom; brightness = 8'($urandom); end
      if (t % PER == LAT - 1) begin
        eg = q_g.pop_front();
        checks++;
        if (wr_write !== 1'b1 || wr_led_num !== 8'(wn % NUM_LEDS) || wr_rgb !== eg) begin
          errors++; $display("FAIL b2b_write px=%0d wr=%b idx=%0d rgb=%h want 1/%0d/%h",
                             wn, wr_write, wr_led_num, wr_rgb, wn % NUM_LEDS, eg);
        end
        checks++;
        if (frame_done !== (wn % NUM_LEDS == NUM_LEDS - 1)) begin
          errors++; $display("FAIL b2b_frame_done px=%0d got=%b want=%b", wn, frame_done, wn % NUM_LEDS == NUM_LEDS - 1);
        end
        wn++;
      end else begin
        checks++;
        if (wr_write !== 1'b0 || frame_done !== 1'b0) begin
          errors++; $display("FAIL b2b_idle t=%0d wr=%b fd=%b want 0/0", t, wr_write, frame_done);
        end
      end
    end
    s_valid = 0;
    checks++;
    if (wn != 9) begin errors++; $display("FAIL b2b_count got=%0d want=9", wn); end
  endtask

  task automatic test_sof_short();
    do_reset();
    for (int i = 0; i < 3; i++) send_check($urandom, 1'b0, 8'($urandom), "sof_pre");
    send_check(24'h0A0B0C, 1'b1, 8'd255, "sof_mid");
    checks++;
    if (wr_led_num !== 8'd0 || short_frame !== 1'b1) begin
      errors++; $display("FAIL sof_mid_const idx=%0d short=%b want 0/1", wr_led_num, short_frame);
    end
    for (int i = 0; i < 3; i++) send_check($urandom, 1'b0, 8'($urandom), "sof_post");
    checks++;
    if (short_frame !== 1'b1) begin errors++; $display("FAIL short_sticky got=%b want=1", short_frame); end
    do_reset();
    checks++;
    if (short_frame !== 1'b0) begin errors++; $display("FAIL short_clear got=%b want=0", short_frame); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_check($urandom, 1'b0, 8'($urandom), "mid_pre0");
    send_check($urandom, 1'b0, 8'($urandom), "mid_pre1");
    s_valid = 1; s_rgb = $urandom; s_sof = 0; brightness = 8'hFF;
    @(posedge clk); #1;
    s_valid = 0; reset = 1;
    #1;
    checks++;
    if (wr_write !== 1'b0) begin errors++; $display("FAIL mid_abort_now got=%b want=0", wr_write); end
    @(posedge clk); #1;
    checks++;
    if (wr_write !== 1'b0 || s_ready !== 1'b1 || wr_led_num !== 8'd0) begin
      errors++; $display("FAIL mid_abort wr=%b rdy=%b idx=%0d want 0/1/0", wr_write, s_ready, wr_led_num);
    end
    reset = 0; m_cnt = 0; m_short = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (wr_write !== 1'b0) begin errors++; $display("FAIL mid_late_write got=%b want=0", wr_write); end
    end
    send_check($urandom, 1'b0, 8'($urandom), "mid_post");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 40; i++)
      send_check($urandom, ($urandom_range(0, 7) == 0), 8'($urandom), "rand");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scale();
    test_back_to_back();
    test_sof_short();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
